// File: rtl/instr_sequencer.sv
// instr_sequencer: issues stored opcodes one per cycle on Instrucao, stalling on disp until Disp_ack.
// Ports: Clock/Reset (sync, active-high); Wr_en/Wr_addr/Wr_data program write (IDLE only);
// Prog_len/Start launch a run; Disp_ack releases a disp stall; Instrucao/Pc current opcode and index;
// Busy high while running; Done one-cycle end pulse.
// Optional SEQ_LOOP_EN: adds Stop, the program wraps to slot 0 until Stop ends it.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter logic [2:0] NOP_CODE = 3'b111
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Wr_en,
  input  logic [AW-1:0] Wr_addr,
  input  logic [2:0]    Wr_data,
  input  logic [AW:0]   Prog_len,
  input  logic          Start,
  input  logic          Disp_ack,
`ifdef SEQ_LOOP_EN
  input  logic          Stop,
`endif
  output logic [2:0]    Instrucao,
  output logic [AW-1:0] Pc,
  output logic          Busy,
  output logic          Done
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
  localparam logic [2:0] DISP = 3'b100;
  logic [2:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [2:0] ins_q, ins_d;
  logic [AW-1:0] pc_q, pc_d, pc_nx;
  logic [AW:0] len_q, len_d;
  logic done_q, done_d, last, adv, fin;
  function automatic logic [2:0] issue(input logic [2:0] op);
    return op > DISP ? NOP_CODE : op;
  endfunction
  assign last = ({1'b0, pc_q} + (AW+1)'(1)) == len_q;
  assign pc_nx = last ? '0 : pc_q + AW'(1);
  // a busy cycle completes unless a disp is still waiting for its acknowledge
  assign adv = state_q == WAIT ? Disp_ack : state_q == RUN && (ins_q != DISP || Disp_ack);
`ifdef SEQ_LOOP_EN
  logic stop_q, stop_d;
  assign fin = stop_q;
  assign stop_d = state_d != IDLE && (stop_q || (state_q != IDLE && Stop));
`else
  assign fin = last;
`endif
  always_comb begin
    state_d = state_q;
    ins_d = ins_q;
    pc_d = pc_q;
    len_d = len_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (Start && Prog_len == '0) done_d = 1'b1;
      else if (Start) begin
        state_d = RUN;
        len_d = Prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : Prog_len;
        pc_d = '0;
        ins_d = issue(mem[0]);
      end
    end else if (adv) begin
      state_d = fin ? IDLE : RUN;
      pc_d = fin ? '0 : pc_nx;
      ins_d = fin ? NOP_CODE : issue(mem[pc_nx]);
      done_d = fin;
    end else state_d = WAIT;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ins_q <= NOP_CODE;
      pc_q <= '0;
      len_q <= '0;
      done_q <= 1'b0;
`ifdef SEQ_LOOP_EN
      stop_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ins_q <= ins_d;
      pc_q <= pc_d;
      len_q <= len_d;
      done_q <= done_d;
`ifdef SEQ_LOOP_EN
      stop_q <= stop_d;
`endif
    end
  end
  always_ff @(posedge Clock) begin
    if (Wr_en && state_q == IDLE) mem[Wr_addr] <= Wr_data;
  end
  assign Instrucao = ins_q;
  assign Pc = pc_q;
  assign Busy = state_q != IDLE;
  assign Done = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and randomized checks of instr_sequencer against a behavioural model.
module tb_instr_sequencer;
  logic Clock = 1'b0, Reset = 1'b1, Wr_en = 1'b0, Start = 1'b0, Disp_ack = 1'b0, Stop = 1'b0;
  logic [3:0] Wr_addr = '0;
  logic [2:0] Wr_data = '0;
  logic [4:0] Prog_len = '0;
  logic [2:0] Instrucao;
  logic [3:0] Pc;
  logic Busy, Done;
  int checks = 0, errors = 0;
  always #5 Clock = ~Clock;
  instr_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
    .Prog_len(Prog_len), .Start(Start), .Disp_ack(Disp_ack),
`ifdef SEQ_LOOP_EN
    .Stop(Stop),
`endif
    .Instrucao(Instrucao), .Pc(Pc), .Busy(Busy), .Done(Done)
  );
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  // model: a program is the list mm[0..len-1]; one entry per completed cycle, disp waits for ack
  logic [2:0] mm [16];
  logic [2:0] m_ins = 3'b111;
  logic [3:0] m_pc = '0;
  int m_len = 0;
  bit m_run = 0, m_done = 0, m_stop = 0, m_en = 0;
  function automatic logic [2:0] op(input logic [2:0] x);
    return x > 3'b100 ? 3'b111 : x;
  endfunction
  always @(posedge Clock) begin
    bit run0, end_now;
    int nx;
    run0 = m_run;
    m_done = 0;
    if (Reset) begin
      m_run = 0; m_ins = 3'b111; m_pc = '0; m_en = 1;
    end else if (!m_run) begin
      if (Start && Prog_len == 0) m_done = 1;
      else if (Start) begin
        m_len = Prog_len > 16 ? 16 : int'(Prog_len);
        m_run = 1; m_pc = '0; m_ins = op(mm[0]);
      end
    end else if (m_ins != 3'b100 || Disp_ack) begin
      end_now = LOOP ? m_stop : (int'(m_pc) + 1 == m_len);
      if (end_now) begin
        m_run = 0; m_ins = 3'b111; m_pc = '0; m_done = 1;
      end else begin
        nx = (int'(m_pc) + 1) % m_len;
        m_pc = 4'(nx); m_ins = op(mm[nx]);
      end
    end
    m_stop = m_run && (m_stop || (run0 && Stop));
    if (!run0 && Wr_en) mm[Wr_addr] = Wr_data;
  end
  always @(negedge Clock) if (m_en) begin
    chk("model_ins", 32'(Instrucao), 32'(m_ins));
    chk("model_pc", 32'(Pc), 32'(m_pc));
    chk("model_busy", 32'(Busy), 32'(m_run));
    chk("model_done", 32'(Done), 32'(m_done));
  end
  task automatic nx();
    @(negedge Clock);
  endtask
  task automatic wr(input int a, input int d);
    Wr_en = 1'b1; Wr_addr = 4'(a); Wr_data = 3'(d);
    nx();
    Wr_en = 1'b0;
  endtask
  task automatic go(input int len);
    Prog_len = 5'(len); Start = 1'b1;
    nx();
    Start = 1'b0;
  endtask
  task automatic exp(input string n, input int i, input int p, input int b, input int d);
    chk({n, "_ins"}, 32'(Instrucao), 32'(i));
    chk({n, "_pc"}, 32'(Pc), 32'(p));
    chk({n, "_busy"}, 32'(Busy), 32'(b));
    chk({n, "_done"}, 32'(Done), 32'(d));
  endtask
  initial begin
    nx(); nx();
    Reset = 1'b0;
    nx();
    exp("reset", 7, 0, 0, 0);
`ifndef SEQ_LOOP_EN
    for (int i = 0; i < 4; i++) wr(i, i);
    go(4);
    for (int i = 0; i < 4; i++) begin
      exp("seq", i, i, 1, 0);
      nx();
    end
    exp("seq_end", 7, 0, 0, 1);
    wr(0, 0); wr(1, 4);
    Disp_ack = 1'b0;
    go(2);
    exp("disp_first", 0, 0, 1, 0);
    nx();
    for (int k = 0; k < 6; k++) begin
      exp("disp_hold", 4, 1, 1, 0);
      if (k == 5) Disp_ack = 1'b1;
      nx();
    end
    Disp_ack = 1'b0;
    exp("disp_end", 7, 0, 0, 1);
    go(0);
    exp("len0", 7, 0, 0, 1);
    nx();
    exp("len0_after", 7, 0, 0, 0);
    wr(1, 1);
    go(4);
    exp("wrrun0", 0, 0, 1, 0);
    Wr_en = 1'b1; Wr_addr = 4'd1; Wr_data = 3'b011;
    nx();
    Wr_en = 1'b0;
    exp("wrrun_old", 1, 1, 1, 0);
    nx(); nx(); nx();
    exp("wrrun_end", 7, 0, 0, 1);
    wr(1, 3);
    go(4);
    nx();
    exp("wrrun_new", 3, 1, 1, 0);
    nx(); nx(); nx(); nx();
`endif
    for (int i = 0; i < 6; i++) wr(i, i % 4);
    Disp_ack = 1'b1;
    go(6);
    nx(); nx();
    exp("rst_mid", 2, 2, 1, 0);
    Reset = 1'b1;
    nx();
    Reset = 1'b0;
    exp("rst_next", 7, 0, 0, 0);
    nx();
    exp("rst_after", 7, 0, 0, 0);
`ifdef SEQ_LOOP_EN
    wr(0, 1); wr(1, 2); wr(2, 4);
    go(3);
    for (int i = 0; i < 5; i++) begin
      exp("loop", i % 3 == 0 ? 1 : i % 3 == 1 ? 2 : 4, i % 3, 1, 0);
      if (i == 4) Stop = 1'b1;
      nx();
    end
    Stop = 1'b0;
    exp("loop_last", 4, 2, 1, 0);
    nx();
    exp("loop_done", 7, 0, 0, 1);
`endif
    for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 7)));
    for (int c = 0; c < 3000; c++) begin
      Reset = $urandom_range(0, 149) == 0;
      Start = $urandom_range(0, 3) == 0;
      Wr_en = $urandom_range(0, 2) == 0;
      Wr_addr = 4'($urandom_range(0, 15));
      Wr_data = 3'($urandom_range(0, 7));
      Prog_len = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      Disp_ack = $urandom_range(0, 1) == 1;
      Stop = LOOP && $urandom_range(0, 19) == 0;
      nx();
    end
    Reset = 1'b0; Start = 1'b0; Wr_en = 1'b0; Stop = 1'b0;
    nx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
